// File: rtl/mk14_keypad_if.sv
// mk14_keypad_if: key-scan input, key-code queue handshake and status for the MK14 keypad front-end.
interface mk14_keypad_if #(
  parameter int KEY_COUNT = 20
);
  logic                 i_scan_valid;
  logic [KEY_COUNT-1:0] i_keys;
  logic                 o_key_valid;
  logic [7:0]           o_key_code;
  logic                 i_key_ack;
  logic                 o_any_key;
  logic                 o_overflow;
  logic                 i_clear;
  modport master (
    output i_scan_valid, i_keys, i_key_ack, i_clear,
    input  o_key_valid, o_key_code, o_any_key, o_overflow
  );
  modport slave (
    input  i_scan_valid, i_keys, i_key_ack, i_clear,
    output o_key_valid, o_key_code, o_any_key, o_overflow
  );
endinterface

// File: rtl/mk14_keypad.sv
// mk14_keypad: debounces key snapshots, detects presses and queues MK14 key codes in a small FIFO.
module mk14_keypad #(
  parameter int KEY_COUNT      = 20,
  parameter int DEBOUNCE_SCANS = 3,
  parameter int FIFO_DEPTH     = 4
) (
  input logic          clk,
  input logic          rst_n,
  mk14_keypad_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int RW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [RW-1:0] DB   = RW'(DEBOUNCE_SCANS);
  localparam logic [AW:0]   FULL = (AW + 1)'(FIFO_DEPTH);
  logic [KEY_COUNT-1:0] r_raw_prev, r_stable, r_pending;
  logic [KEY_COUNT-1:0] w_new, w_lsb;
  logic [RW-1:0]        r_run, w_run_next;
  logic [7:0]           r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_head, r_tail;
  logic [AW:0]          r_count;
  logic                 r_overflow;
  logic                 w_upd, w_has, w_pop, w_push, w_drop;
  logic [4:0]           w_k;
  logic [7:0]           w_code;
  assign w_run_next = (bus.i_keys != r_raw_prev) ? RW'(1) : (r_run == DB) ? DB : r_run + 1'b1;
  assign w_upd      = bus.i_scan_valid && (w_run_next == DB);
  assign w_new      = w_upd ? (bus.i_keys & ~r_stable) : '0;
  assign w_has      = |r_pending;
  // Isolate the lowest pending key so exactly one code is serviced per cycle.
  assign w_lsb      = r_pending & (~r_pending + 1'b1);
  always_comb begin
    w_k = '0;
    for (int j = KEY_COUNT - 1; j >= 0; j--)
      if (r_pending[j]) w_k = 5'(j);
  end
  assign w_code = w_k[4] ? {6'b001000, w_k[1:0]} : {4'h0, w_k[3:0]};
  assign w_pop  = bus.i_key_ack && (r_count != '0);
  assign w_push = w_has && ((r_count != FULL) || w_pop);
  assign w_drop = w_has && !w_push;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw_prev <= '0;
      r_run      <= '0;
      r_stable   <= '0;
      r_pending  <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (bus.i_scan_valid) begin
        r_raw_prev <= bus.i_keys;
        r_run      <= w_run_next;
      end
      if (w_upd) r_stable <= bus.i_keys;
      r_pending  <= (r_pending & ~w_lsb) | w_new;
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop) r_head <= r_head + 1'b1;
      r_count    <= r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
      r_overflow <= w_drop || (r_overflow && !bus.i_clear);
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_tail] <= w_code;
  assign bus.o_key_valid = (r_count != '0);
  assign bus.o_key_code  = bus.o_key_valid ? r_mem[r_head] : 8'h00;
  assign bus.o_any_key   = |r_stable;
  assign bus.o_overflow  = r_overflow;
endmodule

// File: tb/tb_mk14_keypad.sv
// tb_mk14_keypad: directed scenarios plus random scans, checked every cycle against a queue-based model.
module tb_mk14_keypad;
  localparam int KC = 20, DB = 3, DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  mk14_keypad_if #(.KEY_COUNT(KC)) kp ();
  mk14_keypad #(.KEY_COUNT(KC), .DEBOUNCE_SCANS(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(kp)
  );
  int n_chk = 0, n_fail = 0;
  logic [KC-1:0] m_stable, m_pend;
  logic [KC-1:0] m_hist[$];
  int m_q[$];
  bit m_ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int code_of(input int k);
    return (k < 16) ? k : 32'h20 + k - 16;
  endfunction

  task automatic model_reset();
    m_stable = '0;
    m_pend   = '0;
    m_hist.delete();
    m_q.delete();
    m_ovf    = 1'b0;
  endtask

  // Stable follows a snapshot once the last DB scans since reset are all identical.
  task automatic model_step(input bit sv, input logic [KC-1:0] keys, input bit ack, input bit clr);
    logic [KC-1:0] nw = '0;
    bit eq = 1'b1, drop = 1'b0;
    int k = 0;
    if (sv) begin
      m_hist.push_back(keys);
      if (m_hist.size() > DB) void'(m_hist.pop_front());
      foreach (m_hist[i]) if (m_hist[i] !== keys) eq = 1'b0;
      if (m_hist.size() == DB && eq) begin
        nw = keys & ~m_stable;
        m_stable = keys;
      end
    end
    if (ack && m_q.size() > 0) void'(m_q.pop_front());
    if (m_pend != '0) begin
      for (int i = 0; i < KC; i++) if (m_pend[i]) begin k = i; break; end
      m_pend[k] = 1'b0;
      if (m_q.size() < DEPTH) m_q.push_back(code_of(k));
      else drop = 1'b1;
    end
    m_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_pend = m_pend | nw;
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(kp.i_scan_valid, kp.i_keys, kp.i_key_ack, kp.i_clear);
    #1;
    chk("valid", kp.o_key_valid, m_q.size() != 0);
    chk("code", kp.o_key_code, (m_q.size() != 0) ? m_q[0] : 0);
    chk("any_key", kp.o_any_key, m_stable != '0);
    chk("overflow", kp.o_overflow, m_ovf);
  end

  task automatic tick(input bit sv, input logic [KC-1:0] k, input bit ack = 1'b0, input bit clr = 1'b0);
    @(negedge clk);
    kp.i_scan_valid = sv;
    kp.i_keys       = k;
    kp.i_key_ack    = ack;
    kp.i_clear      = clr;
  endtask

  task automatic scan(input logic [KC-1:0] k, input int n);
    repeat (n) tick(1'b1, k);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0);
  endtask

  logic [KC-1:0] pat[4];
  logic [KC-1:0] cur, keys;

  initial begin
    kp.i_scan_valid = 1'b0;
    kp.i_keys       = '0;
    kp.i_key_ack    = 1'b0;
    kp.i_clear      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", kp.o_key_valid, 0);
    chk("rst_code", kp.o_key_code, 8'h00);
    chk("rst_any", kp.o_any_key, 0);
    chk("rst_ovf", kp.o_overflow, 0);
    rst_n = 1'b1;
    // single press, 2-cycle latency
    scan(20'h00020, 3);
    idle(1);
    chk("lat_any", kp.o_any_key, 1);
    chk("lat_valid_e0", kp.o_key_valid, 0);
    idle(1);
    chk("lat_valid_e1", kp.o_key_valid, 1);
    chk("lat_code", kp.o_key_code, 8'h05);
    tick(1'b0, '0, 1'b1);
    idle(1);
    chk("ack_valid", kp.o_key_valid, 0);
    scan('0, 3);
    // bounce
    scan(20'h1, 1); scan(20'h0, 1); scan(20'h1, 3);
    idle(1);
    chk("bounce_e0", kp.o_key_valid, 0);
    idle(1);
    chk("bounce_valid", kp.o_key_valid, 1);
    chk("bounce_code", kp.o_key_code, 8'h00);
    tick(1'b0, '0, 1'b1);
    scan('0, 3);
    // multi-press: bits 17, 12, 3
    scan(20'h21008, 3);
    idle(4);
    chk("multi_first", kp.o_key_code, 8'h03);
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b1);
    chk("multi_second", kp.o_key_code, 8'h0C);
    tick(1'b0, '0, 1'b1);
    chk("multi_third", kp.o_key_code, 8'h21);
    idle(1);
    chk("multi_empty", kp.o_key_valid, 0);
    scan('0, 3);
    // overflow
    for (int k = 1; k <= 5; k++) begin
      scan(KC'(1) << k, 3);
      scan('0, 3);
    end
    idle(1);
    chk("ovf_set", kp.o_overflow, 1);
    chk("ovf_head", kp.o_key_code, 8'h01);
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(1);
    chk("ovf_clear", kp.o_overflow, 0);
    scan(KC'(1) << 6, 3);
    tick(1'b0, '0, 1'b1);
    idle(1);
    chk("full_pushpop_ovf", kp.o_overflow, 0);
    chk("full_pushpop_head", kp.o_key_code, 8'h02);
    repeat (4) tick(1'b0, '0, 1'b1);
    idle(1);
    chk("drain_empty", kp.o_key_valid, 0);
    scan('0, 3);
    // hold and release key 16
    scan(KC'(1) << 16, 10);
    chk("hold_any", kp.o_any_key, 1);
    chk("hold_code", kp.o_key_code, 8'h20);
    scan('0, 3);
    chk("rel2_any", kp.o_any_key, 1);
    idle(1);
    chk("rel3_any", kp.o_any_key, 0);
    tick(1'b0, '0, 1'b1);
    idle(1);
    chk("hold_single", kp.o_key_valid, 0);
    // async reset with queued and pending keys
    scan(20'h00380, 3);
    idle(3);
    chk("pre_rst_valid", kp.o_key_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", kp.o_key_valid, 0);
    chk("arst_code", kp.o_key_code, 8'h00);
    chk("arst_any", kp.o_any_key, 0);
    chk("arst_ovf", kp.o_overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    chk("post_rst_valid", kp.o_key_valid, 0);
    // random traffic
    foreach (pat[i]) pat[i] = KC'($urandom & $urandom);
    cur = '0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) cur = pat[$urandom_range(0, 3)];
      if ($urandom_range(0, 15) == 0) cur = '0;
      keys = ($urandom_range(0, 9) == 0) ? cur ^ (KC'(1) << $urandom_range(0, KC - 1)) : cur;
      tick($urandom_range(0, 1) == 1, keys, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
    end
    idle(2);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/mk14_keypad.md
# mk14_keypad

Keypad front-end for the MK14 SoC: sits downstream of the TM1638 key-read path, which delivers raw key-matrix snapshots. Debounces each snapshot vector, detects new key presses, and translates each pressed key index into an MK14 key code. Queues the codes in a small FIFO that the core side drains with a valid/ack handshake.

## Interface
- `KEY_COUNT`, 20: number of raw key inputs, 1..20.
- `DEBOUNCE_SCANS`, 3: consecutive identical scans required before the stable vector updates, ≥1.
- `FIFO_DEPTH`, 4: key-code queue depth, power of two, ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_scan_valid`  in  1  one-cycle strobe; `i_keys` is a new snapshot.
- `i_keys`  in  KEY_COUNT  raw key levels, 1 = pressed; sampled only when `i_scan_valid`=1.
- `o_key_valid`  out  1  FIFO non-empty; `o_key_code` holds the head entry.
- `o_key_code`  out  8  MK14 key code at the FIFO head.
- `i_key_ack`  in  1  pops the head when `o_key_valid`=1; ignored when the FIFO is empty.
- `o_any_key`  out  1  OR of the stable vector (a key is currently held).
- `o_overflow`  out  1  sticky; a press was dropped because the FIFO was full.
- `i_clear`  in  1  synchronous; clears `o_overflow` only.

## Operation
- Registers: `raw_prev[KEY_COUNT]`, `run` (saturates at DEBOUNCE_SCANS), `stable[KEY_COUNT]`, `pending[KEY_COUNT]`, FIFO storage, head/tail pointers, and a count of log2(FIFO_DEPTH)+1 bits.
- Each clock edge with `i_scan_valid`=1:
  - If `i_keys`==`raw_prev`, `run_next` = min(`run`+1, DEBOUNCE_SCANS); otherwise `run_next` = 1.
  - `raw_prev` <= `i_keys`; `run` <= `run_next`.
  - If `run_next`==DEBOUNCE_SCANS: `stable` <= `i_keys`, and `pending` gains the bits set in (`i_keys` & ~`stable`).
- Releases only clear `stable` bits. Nothing is queued on release.
- Push stage, every cycle:
  - If `pending`≠0, take the lowest set index k and clear bit k. The clear is ORed correctly with any same-cycle new presses.
  - Enqueue code(k) if the FIFO is not full, or if it is full and a pop happens in the same cycle.
  - Otherwise drop k and set `o_overflow`.
- Code map:
  - k = 0..15 maps to 8'h00..8'h0F (hex digits).
  - k = 16..19 map to GO 8'h20, MEM 8'h21, ABORT 8'h22, TERM 8'h23.
- Pop: `i_key_ack` & `o_key_valid` advances the head.
- Simultaneous push and pop: the count is unchanged and both actions take effect.
- Pointers wrap modulo FIFO_DEPTH.
- `i_clear` and a new overflow in the same cycle: the overflow wins, so `o_overflow`=1.

## Timing
- Reset (rst_n low, asynchronous) forces:
  - `raw_prev`, `run`, `stable`, and `pending` to 0.
  - FIFO empty.
  - `o_key_valid`=0, `o_key_code`=8'h00, `o_any_key`=0, `o_overflow`=0.
- Reset mid-operation discards queued and pending keys.
- Outputs are all registered or derived from registered state. There is no combinational path from inputs to outputs.
- Latency, with strobe sampled at edge E0 completing debounce:
  - `stable`/`pending`/`o_any_key` update after E0.
  - Push at E1; `o_key_valid`=1 and `o_key_code` valid after E1.
  - Total: 2 cycles from strobe to valid.
- N keys newly pressed in one scan enqueue on N consecutive cycles, lowest index first.
- Pop at edge E: the next head is visible after E. `o_key_valid` falls after E if the FIFO became empty.
- Strobes may arrive back-to-back every cycle.
- With DEBOUNCE_SCANS=1, every strobe updates `stable`.

## Test plan
- Reset, then three strobes with `i_keys`=20'h00020 (DEBOUNCE=3): `o_key_valid` rises 2 cycles after the 3rd strobe, `o_key_code`=8'h05, `o_any_key`=1. Ack: valid drops next cycle.
- Bounce: scans 0x1, 0x0, 0x1, 0x1, 0x1: exactly one code 8'h00 is queued, after the 5th scan. No earlier press is queued.
- Multi-press: one debounced scan with bits 17, 3, and 12 set: codes 8'h03, 8'h0C, 8'h21 are enqueued on three consecutive cycles. Ack order matches.
- Overflow (depth 4, no ack): press and release 5 distinct keys: FIFO holds the first 4 codes and `o_overflow`=1. `i_clear` drops it to 0. A full FIFO with a same-cycle ack and push has no overflow.
- Hold and release: key 16 held for 10 scans, then released for 3 scans: a single 8'h20 is queued. `o_any_key` goes 1 and then 0 after the 3rd release scan.
- Async reset asserted mid-cycle with 2 queued codes and pending bits: all outputs go to 0 immediately. After release, no stale codes appear.
